// File: rtl/ts_pkg.sv
// Shared types and defaults for the per-lane TS transmit buffer.
package ts_pkg;

    localparam int unsigned TS_W_DEF  = 128;
    localparam int unsigned SYM_W_DEF = 8;
    localparam int unsigned NSYM_DEF  = TS_W_DEF / SYM_W_DEF;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_e;

    // Width of a level counter that can hold 0..depth inclusive.
    function automatic int unsigned level_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ts_sync_fifo.sv
// Single-clock queue of whole ordered sets with level, full and empty decode.
module ts_sync_fifo
    import ts_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = TS_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        wr_en,
    input  logic [W-1:0]                wr_data,
    input  logic                        rd_en,
    output logic [W-1:0]                rd_data,
    output logic [level_w(DEPTH)-1:0]   level,
    output logic                        full,
    output logic                        empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = level_w(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_wr;
    logic             do_rd;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr_q];
    assign level   = level_q;

    // Storage carries no reset; validity is tracked by the level alone.
    always_ff @(posedge clk) begin
        if (do_wr && !flush) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/ts_tx_buffer.sv
// Per-lane TS transmit buffer: queues ordered sets and serializes them LSB symbol first.
// Optional completed-TS counter is built only when TS_TX_STATS_EN is defined.
module ts_tx_buffer
    import ts_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TS_W  = TS_W_DEF,
    parameter int unsigned SYM_W = SYM_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [TS_W-1:0]             ts_i,
    input  logic                        ts_i_vld,
    output logic                        tx_fifo_full,
    output logic [SYM_W-1:0]            sym_o,
    output logic                        sym_o_vld,
    input  logic                        sym_o_rdy,
    output logic                        sym_o_sot,
    output logic                        sym_o_eot,
    output logic [level_w(DEPTH)-1:0]   ts_level,
    output logic                        ovf_err,
    output logic [15:0]                 ts_sent_cnt
);

    localparam int unsigned NSYM  = TS_W / SYM_W;
    localparam int unsigned IDX_W = (NSYM > 1) ? $clog2(NSYM) : 1;

    tx_state_e        state_q, state_d;
    logic [TS_W-1:0]  shreg_q, shreg_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             vld_q, vld_d;
    logic             sot_q, sot_d;
    logic             eot_q, eot_d;
    logic             ovf_q;
    logic             pop;
    logic             fifo_empty;
    logic [TS_W-1:0]  fifo_head;

    ts_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (TS_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .flush   (flush),
        .wr_en   (ts_i_vld),
        .wr_data (ts_i),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .level   (ts_level),
        .full    (tx_fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            sot_q   <= 1'b0;
            eot_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            sot_q   <= sot_d;
            eot_q   <= eot_d;
        end
    end

    // Serializer: a right shift keeps the current symbol in the low bits of shreg.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        sot_d   = sot_q;
        eot_d   = eot_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_head;
                    idx_d   = '0;
                    vld_d   = 1'b1;
                    sot_d   = 1'b1;
                    eot_d   = (NSYM == 1);
                    state_d = SEND;
                end
            end
            SEND: begin
                if (sym_o_rdy) begin
                    if (idx_q == IDX_W'(NSYM - 1)) begin
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shreg_d = fifo_head;
                            idx_d   = '0;
                            sot_d   = 1'b1;
                            eot_d   = (NSYM == 1);
                        end else begin
                            vld_d   = 1'b0;
                            sot_d   = 1'b0;
                            eot_d   = 1'b0;
                            idx_d   = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        shreg_d = shreg_q >> SYM_W;
                        idx_d   = idx_q + IDX_W'(1);
                        sot_d   = 1'b0;
                        eot_d   = ((idx_q + IDX_W'(1)) == IDX_W'(NSYM - 1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush aborts any TS in flight without emitting its eot.
        if (flush) begin
            pop     = 1'b0;
            idx_d   = '0;
            vld_d   = 1'b0;
            sot_d   = 1'b0;
            eot_d   = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (ts_i_vld && tx_fifo_full) begin
            ovf_q <= 1'b1;
        end
    end

    assign sym_o     = shreg_q[SYM_W-1:0];
    assign sym_o_vld = vld_q;
    assign sym_o_sot = sot_q;
    assign sym_o_eot = eot_q;
    assign ovf_err   = ovf_q;

`ifdef TS_TX_STATS_EN
    logic [15:0] sent_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sent_cnt_q <= '0;
        end else if (vld_q && sym_o_rdy && eot_q && (sent_cnt_q != 16'hFFFF)) begin
            sent_cnt_q <= sent_cnt_q + 16'd1;
        end
    end

    assign ts_sent_cnt = sent_cnt_q;
`else
    assign ts_sent_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ts_tx_buffer.sv
// Directed self-checking bench for ts_tx_buffer (DEPTH=4, 128-bit TS, 8-bit symbols).
module tb_ts_tx_buffer;

    logic         clk;
    logic         rst;
    logic         flush;
    logic [127:0] ts_i;
    logic         ts_i_vld;
    logic         tx_fifo_full;
    logic [7:0]   sym_o;
    logic         sym_o_vld;
    logic         sym_o_rdy;
    logic         sym_o_sot;
    logic         sym_o_eot;
    logic [2:0]   ts_level;
    logic         ovf_err;
    logic [15:0]  ts_sent_cnt;

    int n_checks;
    int n_fail;

    ts_tx_buffer #(
        .DEPTH (4),
        .TS_W  (128),
        .SYM_W (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .ts_i         (ts_i),
        .ts_i_vld     (ts_i_vld),
        .tx_fifo_full (tx_fifo_full),
        .sym_o        (sym_o),
        .sym_o_vld    (sym_o_vld),
        .sym_o_rdy    (sym_o_rdy),
        .sym_o_sot    (sym_o_sot),
        .sym_o_eot    (sym_o_eot),
        .ts_level     (ts_level),
        .ovf_err      (ovf_err),
        .ts_sent_cnt  (ts_sent_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte i of pattern k is {k[3:0], i[3:0]}; k=0 gives 0x0F0E..0100.
    function automatic logic [127:0] mk_ts(input int k);
        logic [127:0] d;
        for (int i = 0; i < 16; i++) begin
            d[i*8 +: 8] = {4'(k), 4'(i)};
        end
        return d;
    endfunction

    function automatic logic [7:0] mk_sym(input int k, input int i);
        return {4'(k), 4'(i)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_ts(input logic [127:0] d);
        ts_i     = d;
        ts_i_vld = 1'b1;
        tick();
        ts_i_vld = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        n_checks++;
        if ({sym_o_vld, sym_o_sot, sym_o_eot, tx_fifo_full, ovf_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b exp 00000", {sym_o_vld, sym_o_sot, sym_o_eot, tx_fifo_full, ovf_err});
        end
        n_checks++;
        if (ts_level !== 3'd0 || sym_o !== 8'h00 || ts_sent_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_vals: level %0d sym %h cnt %h exp 0/00/0000", ts_level, sym_o, ts_sent_cnt);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        sym_o_rdy = 1'b1;
        write_ts(mk_ts(0));
        n_checks++;
        if (sym_o_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL single_lat_n1: vld got %b exp 0", sym_o_vld);
        end
        tick();
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (sym_o_vld !== 1'b1 || sym_o !== 8'(i) || sym_o_sot !== (i == 0) || sym_o_eot !== (i == 15)) begin
                n_fail++;
                $display("FAIL single_sym%0d: vld %b sym %h sot %b eot %b exp 1 %h %b %b",
                         i, sym_o_vld, sym_o, sym_o_sot, sym_o_eot, 8'(i), (i == 0), (i == 15));
            end
            tick();
        end
        n_checks++;
        if (sym_o_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL single_end: vld got %b exp 0", sym_o_vld);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] rx [128];
        int cnt;
        sym_o_rdy = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            write_ts(mk_ts(k));
        end
        n_checks++;
        if (ts_level !== 3'd4 || tx_fifo_full !== 1'b1 || ovf_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_fill: level %0d full %b ovf %b exp 4 1 0", ts_level, tx_fifo_full, ovf_err);
        end
        write_ts(mk_ts(6));
        n_checks++;
        if (ovf_err !== 1'b1 || ts_level !== 3'd4) begin
            n_fail++;
            $display("FAIL ovf_set: ovf %b level %0d exp 1 4", ovf_err, ts_level);
        end
        sym_o_rdy = 1'b1;
        cnt = 0;
        for (int c = 0; c < 200; c++) begin
            if (sym_o_vld) begin
                if (cnt < 128) rx[cnt] = sym_o;
                cnt++;
            end
            tick();
        end
        n_checks++;
        if (cnt != 80) begin
            n_fail++;
            $display("FAIL ovf_count: symbols got %0d exp 80", cnt);
        end
        for (int j = 0; j < 80 && j < cnt; j++) begin
            n_checks++;
            if (rx[j] !== mk_sym(1 + j / 16, j % 16)) begin
                n_fail++;
                $display("FAIL ovf_sym%0d: got %h exp %h", j, rx[j], mk_sym(1 + j / 16, j % 16));
            end
        end
        n_checks++;
        if (ovf_err !== 1'b1 || ts_level !== 3'd0 || tx_fifo_full !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_after: ovf %b level %0d full %b exp 1 0 0", ovf_err, ts_level, tx_fifo_full);
        end
    endtask

    task automatic test_rdy_toggle();
        int exp_idx;
        int cyc;
        sym_o_rdy = 1'b0;
        write_ts(mk_ts(7));
        tick();
        exp_idx = 0;
        cyc = 0;
        while (exp_idx < 16 && cyc < 64) begin
            n_checks++;
            if (sym_o_vld !== 1'b1 || sym_o !== mk_sym(7, exp_idx) ||
                sym_o_sot !== (exp_idx == 0) || sym_o_eot !== (exp_idx == 15)) begin
                n_fail++;
                $display("FAIL toggle_c%0d: vld %b sym %h sot %b eot %b exp 1 %h %b %b", cyc,
                         sym_o_vld, sym_o, sym_o_sot, sym_o_eot, mk_sym(7, exp_idx), (exp_idx == 0), (exp_idx == 15));
            end
            sym_o_rdy = (cyc % 2 == 0);
            tick();
            if (sym_o_rdy) exp_idx++;
            cyc++;
        end
        n_checks++;
        if (exp_idx != 16 || sym_o_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL toggle_end: idx %0d vld %b exp 16 0", exp_idx, sym_o_vld);
        end
    endtask

    task automatic test_back_to_back();
        sym_o_rdy = 1'b0;
        write_ts(mk_ts(8));
        write_ts(mk_ts(9));
        tick();
        n_checks++;
        if (ts_level !== 3'd1 || sym_o_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_setup: level %0d vld %b exp 1 1", ts_level, sym_o_vld);
        end
        sym_o_rdy = 1'b1;
        for (int c = 0; c <= 32; c++) begin
            n_checks++;
            if (c < 32) begin
                if (sym_o_vld !== 1'b1 || sym_o !== mk_sym(8 + c / 16, c % 16) ||
                    sym_o_sot !== (c % 16 == 0) || sym_o_eot !== (c % 16 == 15)) begin
                    n_fail++;
                    $display("FAIL b2b_c%0d: vld %b sym %h sot %b eot %b exp 1 %h %b %b", c,
                             sym_o_vld, sym_o, sym_o_sot, sym_o_eot, mk_sym(8 + c / 16, c % 16),
                             (c % 16 == 0), (c % 16 == 15));
                end
            end else if (sym_o_vld !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_end: vld got %b exp 0", sym_o_vld);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        sym_o_rdy = 1'b0;
        write_ts(mk_ts(10));
        write_ts(mk_ts(11));
        write_ts(mk_ts(12));
        n_checks++;
        if (ts_level !== 3'd2 || sym_o_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_setup: level %0d vld %b exp 2 1", ts_level, sym_o_vld);
        end
        sym_o_rdy = 1'b1;
        repeat (5) tick();
        n_checks++;
        if (sym_o !== 8'hA5 || sym_o_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_idx5: sym %h vld %b exp a5 1", sym_o, sym_o_vld);
        end
        flush    = 1'b1;
        ts_i     = mk_ts(13);
        ts_i_vld = 1'b1;
        tick();
        flush    = 1'b0;
        ts_i_vld = 1'b0;
        n_checks++;
        if (sym_o_vld !== 1'b0 || ts_level !== 3'd0 || tx_fifo_full !== 1'b0 || sym_o_eot !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_next: vld %b level %0d full %b eot %b exp 0 0 0 0",
                     sym_o_vld, ts_level, tx_fifo_full, sym_o_eot);
        end
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (sym_o_vld !== 1'b0 || sym_o_eot !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_quiet%0d: vld %b eot %b exp 0 0", c, sym_o_vld, sym_o_eot);
            end
            tick();
        end
        write_ts(mk_ts(14));
        tick();
        n_checks++;
        if (sym_o_vld !== 1'b1 || sym_o_sot !== 1'b1 || sym_o !== 8'hE0) begin
            n_fail++;
            $display("FAIL flush_restart: vld %b sot %b sym %h exp 1 1 e0", sym_o_vld, sym_o_sot, sym_o);
        end
        repeat (16) tick();
        n_checks++;
        if (sym_o_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_drain: vld got %b exp 0", sym_o_vld);
        end
    endtask

    task automatic test_reset_mid_ts();
        sym_o_rdy = 1'b1;
        write_ts(mk_ts(3));
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({sym_o_vld, sym_o_sot, sym_o_eot, ovf_err} !== 4'b0 || sym_o !== 8'h00 || ts_level !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_mid: vld %b sot %b eot %b ovf %b sym %h level %0d exp all 0",
                     sym_o_vld, sym_o_sot, sym_o_eot, ovf_err, sym_o, ts_level);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_stats();
`ifdef TS_TX_STATS_EN
        apply_reset();
        sym_o_rdy = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            write_ts(mk_ts(k));
        end
        repeat (60) tick();
        n_checks++;
        if (ts_sent_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL stats_three: got %0d exp 3", ts_sent_cnt);
        end
        force dut.sent_cnt_q = 16'hFFFF;
        tick();
        release dut.sent_cnt_q;
        write_ts(mk_ts(4));
        repeat (20) tick();
        n_checks++;
        if (ts_sent_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL stats_sat: got %h exp ffff", ts_sent_cnt);
        end
`else
        n_checks++;
        if (ts_sent_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL stats_off: got %0d exp 0", ts_sent_cnt);
        end
`endif
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        ts_i      = '0;
        ts_i_vld  = 1'b0;
        sym_o_rdy = 1'b0;
        #3;
        test_reset();
        test_single();
        test_overflow();
        test_rdy_toggle();
        test_back_to_back();
        test_flush();
        test_stats();
        test_reset_mid_ts();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ts_tx_buffer.md
Name: ts_tx_buffer

Overview:
Per-lane transmit buffer between the LTSSM lane TS output (ts_o / ts_o_vld) and the serdes lane. It queues whole 128-bit training-sequence ordered sets, drives the LTSSM's tx_fifo_full back-pressure, and streams each TS out as a sequence of 8-bit symbols over a valid/ready handshake. One instance is used per lane, four per port.

Parameters:
DEPTH, 4, number of TS entries queued; power of two, minimum 2.
TS_W, 128, ordered-set width in bits.
SYM_W, 8, symbol width; TS_W must be an integer multiple of SYM_W. NSYM = TS_W/SYM_W.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
flush  in  1  synchronous clear of queue and serializer (LTSSM state/speed change)
ts_i  in  TS_W  TS from LTSSM
ts_i_vld  in  1  write strobe, one TS per cycle
tx_fifo_full  out  1  queue full; to LTSSM laneN_tx_fifo_full
sym_o  out  SYM_W  current symbol to serdes
sym_o_vld  out  1  symbol valid
sym_o_rdy  in  1  serdes accepts symbol
sym_o_sot  out  1  current symbol is symbol 0 of a TS
sym_o_eot  out  1  current symbol is symbol NSYM-1
ts_level  out  $clog2(DEPTH+1)  queued TS count, excluding the one being serialized
ovf_err  out  1  sticky: write dropped while full
ts_sent_cnt  out  16  completed-TS counter (see Optional Feature)

Behaviour:
- Reset (rst=0, async): queue empty, FSM IDLE, all outputs 0, ts_level=0, ovf_err=0.
- tx_fifo_full = (ts_level==DEPTH), decoded from registered count.
- Write: ts_i_vld && !tx_fifo_full stores ts_i at the write pointer, and the pointer increments modulo DEPTH.
- Overflow: ts_i_vld while tx_fifo_full drops the TS and sets ovf_err. The write is dropped even when a pop happens in the same cycle.
- ovf_err clears only on reset.
- Pop/write in the same cycle: ts_level is unchanged and pointers advance independently.
- FSM states IDLE, SEND.
  - IDLE: if ts_level>0, pop the head into the shift register, set idx=0, go to SEND.
  - SEND: sym_o_vld=1 and sym_o = TS bits [idx*SYM_W +: SYM_W], so symbol 0 is LSBs (bits 7:0) and is sent first.
  - sym_o_sot = (idx==0); sym_o_eot = (idx==NSYM-1).
  - On sym_o_rdy: idx increments. On the last symbol with rdy, pop the next TS in the same cycle if ts_level>0 (no bubble, stay in SEND); otherwise go to IDLE.
  - Without rdy: sym_o, sot and eot hold stable and vld stays asserted.
- Latency: ts_i_vld in cycle N into an empty, idle buffer gives sym_o_vld=1 with sot=1 in cycle N+2.
- Throughput: one symbol per cycle when rdy is held high, i.e. one TS per NSYM cycles.
- flush (synchronous, highest priority after reset): pointers, ts_level and FSM go to IDLE next cycle, and sym_o_vld=0 next cycle.
  - A TS being serialized is aborted with no eot.
  - A ts_i_vld in the flush cycle is discarded.
  - ovf_err and ts_sent_cnt are kept.
- Reset mid-TS: immediate abort, all outputs return to reset values.

Optional Feature:
TS_TX_STATS_EN:
- Defined: ts_sent_cnt increments on every accepted eot symbol (sym_o_vld && sym_o_rdy && sym_o_eot). It saturates at 16'hFFFF and is cleared only by reset.
- Undefined: ts_sent_cnt is tied to 0 and no counter logic is built.

Decomposition:
- Shared package ts_pkg holds:
  - TS_W and SYM_W defaults and NSYM.
  - FSM state typedef (IDLE, SEND).
  - Level-width function.
- One natural sub-module, ts_sync_fifo: a single-clock DEPTH×TS_W memory with pointers, level, full and empty. The serializer FSM stays in the top level.

Test Plan:
- Reset, then one TS 128'h0F0E...0100 written at cycle N with rdy=1 → first sym_o_vld at N+2. Symbols 8'h00..8'h0F follow on consecutive cycles, sot on 8'h00, eot on 8'h0F, then vld=0.
- Write 5 TS back-to-back with rdy=0 and DEPTH=4:
  - 1st TS is popped into the serializer; the next 4 fill the queue, giving ts_level=4 and tx_fifo_full=1.
  - A 6th write sets ovf_err=1 and is not transmitted.
- rdy toggled 1,0,1,0 mid-TS → each symbol is held stable while rdy=0, and no symbols are lost or duplicated.
- Two TS queued with rdy=1 → eot of TS0 is followed in the very next cycle by sot of TS1; 32 consecutive valid cycles.
- flush asserted at symbol idx=5 of TS0 with 2 TS queued → next cycle vld=0, ts_level=0, full=0, no eot seen. A subsequent write restarts at sot.
- With TS_TX_STATS_EN: send 3 TS → ts_sent_cnt=3. Force the count to 16'hFFFF and send one more TS → it stays 16'hFFFF. Without the macro the count reads 0 throughout.
